// File: rtl/key_conditioner_pkg.sv
// Shared constants for the push-button / slide-switch input conditioning stage.
// Keys are active-low, so the released level is 1.
package key_conditioner_pkg;

    localparam int NUM_KEYS            = 4;
    localparam int NUM_SW              = 10;
    localparam logic KEY_RELEASED      = 1'b1;
    localparam int DEBOUNCE_20MS_50MHZ = 1000000;
    localparam int DEBOUNCE_SIM_CYCLES = 4;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: two-flop synchroniser, stability counter, accepted level,
// single-cycle press pulse and press-toggle bit.
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_raw,
    output logic o_clean,
    output logic o_press,
    output logic o_toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= KEY_RELEASED;
            r_s2     <= KEY_RELEASED;
            r_stable <= KEY_RELEASED;
            r_cnt    <= '0;
            r_press  <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_s1    <= i_key_raw;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            // Any agreement with the accepted level restarts the whole window.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
                if (r_s2 != KEY_RELEASED) begin
                    r_press  <= 1'b1;
                    r_toggle <= ~r_toggle;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_clean  = r_stable;
    assign o_press  = r_press;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw DE-board push-buttons and slide switches for the HEX display stage:
// debounced active-low keys with press pulses/toggles, and plainly synchronised switches.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic                CLOCK_50,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_KEYS-1:0] KEY_CLEAN,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_TOGGLE,
    output logic [NUM_SW-1:0]   SW_SYNC
);

    logic [NUM_SW-1:0] r_sw_s1;
    logic [NUM_SW-1:0] r_sw_s2;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk      (CLOCK_50),
            .rst_n    (RST_N),
            .i_key_raw(KEY[g]),
            .o_clean  (KEY_CLEAN[g]),
            .o_press  (KEY_PRESS[g]),
            .o_toggle (KEY_TOGGLE[g])
        );
    end

    // Switches are levels the user sets deliberately; no debounce needed.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign SW_SYNC = r_sw_s2;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a 4-cycle debounce window.
module tb_key_conditioner;
    import key_conditioner_pkg::*;

    logic                CLOCK_50;
    logic                RST_N;
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_SW-1:0]   SW;
    logic [NUM_KEYS-1:0] KEY_CLEAN;
    logic [NUM_KEYS-1:0] KEY_PRESS;
    logic [NUM_KEYS-1:0] KEY_TOGGLE;
    logic [NUM_SW-1:0]   SW_SYNC;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_SIM_CYCLES)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RST_N     (RST_N),
        .KEY       (KEY),
        .SW        (SW),
        .KEY_CLEAN (KEY_CLEAN),
        .KEY_PRESS (KEY_PRESS),
        .KEY_TOGGLE(KEY_TOGGLE),
        .SW_SYNC   (SW_SYNC)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance past the next rising edge; inputs set afterwards are captured on the following edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        KEY   = 4'hF;
        SW    = '0;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        KEY = 4'h0;
        SW  = 10'h3FF;
        repeat (3) tick();
        checks++;
        if (SW_SYNC !== 10'h3FF) begin
            errors++;
            $display("FAIL reset_pre_sw: SW_SYNC=%h expected %h", SW_SYNC, 10'h3FF);
        end
        checks++;
        if (KEY_CLEAN !== 4'hF) begin
            errors++;
            $display("FAIL reset_pre_clean: KEY_CLEAN=%b expected 1111", KEY_CLEAN);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (KEY_CLEAN !== 4'hF) begin
            errors++;
            $display("FAIL reset_async_clean: KEY_CLEAN=%b expected 1111", KEY_CLEAN);
        end
        checks++;
        if (KEY_PRESS !== 4'h0) begin
            errors++;
            $display("FAIL reset_async_press: KEY_PRESS=%b expected 0000", KEY_PRESS);
        end
        checks++;
        if (KEY_TOGGLE !== 4'h0) begin
            errors++;
            $display("FAIL reset_async_toggle: KEY_TOGGLE=%b expected 0000", KEY_TOGGLE);
        end
        checks++;
        if (SW_SYNC !== 10'h000) begin
            errors++;
            $display("FAIL reset_async_sw: SW_SYNC=%h expected 000", SW_SYNC);
        end
        SW = '0;
        #1;
        RST_N = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (KEY_CLEAN !== 4'hF) begin
            errors++;
            $display("FAIL reset_t4_clean: KEY_CLEAN=%b expected 1111", KEY_CLEAN);
        end
        tick();
        checks++;
        if (KEY_CLEAN !== 4'h0) begin
            errors++;
            $display("FAIL reset_t5_clean: KEY_CLEAN=%b expected 0000", KEY_CLEAN);
        end
        checks++;
        if (KEY_PRESS !== 4'hF) begin
            errors++;
            $display("FAIL reset_t5_press: KEY_PRESS=%b expected 1111", KEY_PRESS);
        end
        tick();
        checks++;
        if (KEY_PRESS !== 4'h0) begin
            errors++;
            $display("FAIL reset_t6_press: KEY_PRESS=%b expected 0000", KEY_PRESS);
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        KEY = 4'b1011;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (KEY_CLEAN !== 4'hF || KEY_PRESS !== 4'h0) begin
                errors++;
                $display("FAIL press_wait%0d: KEY_CLEAN=%b KEY_PRESS=%b expected 1111/0000",
                         i, KEY_CLEAN, KEY_PRESS);
            end
        end
        tick();
        checks++;
        if (KEY_CLEAN !== 4'b1011 || KEY_PRESS !== 4'b0100 || KEY_TOGGLE !== 4'b0100) begin
            errors++;
            $display("FAIL press_accept: CLEAN=%b PRESS=%b TOGGLE=%b expected 1011/0100/0100",
                     KEY_CLEAN, KEY_PRESS, KEY_TOGGLE);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (KEY_CLEAN !== 4'b1011 || KEY_PRESS !== 4'h0 || KEY_TOGGLE !== 4'b0100) begin
                errors++;
                $display("FAIL press_hold%0d: CLEAN=%b PRESS=%b TOGGLE=%b expected 1011/0000/0100",
                         i, KEY_CLEAN, KEY_PRESS, KEY_TOGGLE);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [7];
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            KEY = {3'b111, pat[i]};
            tick();
            checks++;
            if (KEY_CLEAN !== 4'hF || KEY_PRESS !== 4'h0) begin
                errors++;
                $display("FAIL bounce_in%0d: CLEAN=%b PRESS=%b expected 1111/0000",
                         i, KEY_CLEAN, KEY_PRESS);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (KEY_CLEAN !== 4'hF || KEY_PRESS !== 4'h0) begin
                errors++;
                $display("FAIL bounce_after%0d: CLEAN=%b PRESS=%b expected 1111/0000",
                         i, KEY_CLEAN, KEY_PRESS);
            end
        end
    endtask

    task automatic test_release_repeat();
        logic [NUM_KEYS-1:0] key_seq [3];
        logic [NUM_KEYS-1:0] tog_exp [3];
        int                  pulse_exp [3];
        int                  pulses;
        int                  stray;
        key_seq   = '{4'b1101, 4'b1111, 4'b1101};
        tog_exp   = '{4'b0010, 4'b0010, 4'b0000};
        pulse_exp = '{1, 0, 1};
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            KEY    = key_seq[p];
            pulses = 0;
            stray  = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (KEY_PRESS[1]) pulses++;
                if ((KEY_PRESS & 4'b1101) != 4'h0) stray++;
            end
            checks++;
            if (pulses != pulse_exp[p] || stray != 0) begin
                errors++;
                $display("FAIL repeat_pulses%0d: key1 pulses=%0d other=%0d expected %0d/0",
                         p, pulses, stray, pulse_exp[p]);
            end
            checks++;
            if (KEY_CLEAN !== key_seq[p] || KEY_TOGGLE !== tog_exp[p]) begin
                errors++;
                $display("FAIL repeat_state%0d: CLEAN=%b TOGGLE=%b expected %b/%b",
                         p, KEY_CLEAN, KEY_TOGGLE, key_seq[p], tog_exp[p]);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        KEY = 4'h0;
        tick();
        repeat (4) tick();
        checks++;
        if (KEY_PRESS !== 4'h0) begin
            errors++;
            $display("FAIL simul_early: KEY_PRESS=%b expected 0000", KEY_PRESS);
        end
        tick();
        checks++;
        if (KEY_PRESS !== 4'hF || KEY_TOGGLE !== 4'hF || KEY_CLEAN !== 4'h0) begin
            errors++;
            $display("FAIL simul_accept: PRESS=%b TOGGLE=%b CLEAN=%b expected 1111/1111/0000",
                     KEY_PRESS, KEY_TOGGLE, KEY_CLEAN);
        end
        tick();
        checks++;
        if (KEY_PRESS !== 4'h0 || KEY_TOGGLE !== 4'hF) begin
            errors++;
            $display("FAIL simul_after: PRESS=%b TOGGLE=%b expected 0000/1111",
                     KEY_PRESS, KEY_TOGGLE);
        end
    endtask

    task automatic test_switch();
        apply_reset();
        SW = 10'h200;
        tick();
        checks++;
        if (SW_SYNC !== 10'h000) begin
            errors++;
            $display("FAIL sw_t0: SW_SYNC=%h expected 000", SW_SYNC);
        end
        tick();
        checks++;
        if (SW_SYNC !== 10'h200) begin
            errors++;
            $display("FAIL sw_t1: SW_SYNC=%h expected 200", SW_SYNC);
        end
        checks++;
        if (KEY_CLEAN !== 4'hF || KEY_PRESS !== 4'h0 || KEY_TOGGLE !== 4'h0) begin
            errors++;
            $display("FAIL sw_keys: CLEAN=%b PRESS=%b TOGGLE=%b expected 1111/0000/0000",
                     KEY_CLEAN, KEY_PRESS, KEY_TOGGLE);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        KEY   = 4'hF;
        SW    = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_repeat();
        test_simultaneous();
        test_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
